// File: rtl/piece_lock_controller.sv
// Piece lock controller: lock delay, merge of the resting piece and row clearing for the playfield.
// Optional build macro LOCK_RESET_ON_MOVE_EN lets player moves restart the lock delay (bounded per piece).

package game_state_pkg;
   localparam int unsigned BOARD_WIDTH  = 10;
   localparam int unsigned BOARD_HEIGHT = 20;

   typedef struct packed {
      logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen;
   } game_state_t;
endpackage

package tetris_pkg;
   localparam int unsigned POS_W = 6;

   // piece[ly][lx]; (x, y) is the board position of grid cell (0, 0)
   typedef struct packed {
      logic signed [POS_W-1:0] x;
      logic signed [POS_W-1:0] y;
      logic [3:0][3:0]         piece;
   } active_piece_grid_t;
endpackage

module piece_lock_controller #(
   parameter int unsigned LOCK_TICKS      = 2,
   parameter int unsigned MAX_LOCK_RESETS = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  tetris_pkg::active_piece_grid_t active_piece_grid,
   input  logic                           active_piece_toutching,
   input  logic                           gravity_tick,
   input  logic                           hard_drop,
   input  logic                           piece_moved,
   output game_state_pkg::game_state_t    GAME_fixed_state,
   output logic                           lock_busy,
   output logic                           spawn_req,
   output logic [2:0]                     lines_cleared,
   output logic                           top_out
);

   localparam int unsigned W       = game_state_pkg::BOARD_WIDTH;
   localparam int unsigned H       = game_state_pkg::BOARD_HEIGHT;
   localparam int unsigned ROW_W   = 5;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned LINES_W = 3;
   localparam int unsigned COORD_W = tetris_pkg::POS_W + 1;

   localparam logic signed [COORD_W-1:0] ZERO     = '0;
   localparam logic signed [COORD_W-1:0] LAST_ROW = COORD_W'(H - 1);
   localparam logic signed [COORD_W-1:0] LAST_COL = COORD_W'(W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_MERGE,
      ST_SCAN,
      ST_DONE,
      ST_DEAD
   } state_e;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            lock_cnt_q, lock_cnt_d;
   logic [ROW_W-1:0]            row_q, row_d;
   logic [LINES_W-1:0]          count_q, count_d;
   logic [LINES_W-1:0]          lines_q, lines_d;
   game_state_pkg::game_state_t screen_q, screen_d;
   logic                        spawn_q, spawn_d;
   logic                        busy_q, busy_d;
   logic                        top_out_q, top_out_d;

`ifdef LOCK_RESET_ON_MOVE_EN
   logic [CNT_W-1:0] resets_q, resets_d;
   logic             move_accept;

   assign move_accept = piece_moved && (resets_q < CNT_W'(MAX_LOCK_RESETS));
`else
   logic unused_cfg;

   assign unused_cfg = ^{piece_moved, CNT_W'(MAX_LOCK_RESETS)};
`endif

   // Merge candidate: piece ORed into the board, plus collision / above-the-top detection
   game_state_pkg::game_state_t merge_screen;
   logic                        merge_dead;
   logic signed [COORD_W-1:0]   wx, wy;
   logic [ROW_W-1:0]            cell_bit;

   always_comb begin
      merge_screen = screen_q;
      merge_dead   = 1'b0;
      wx           = '0;
      wy           = '0;
      cell_bit     = '0;
      for (int ly = 0; ly < 4; ly++) begin
         for (int lx = 0; lx < 4; lx++) begin
            wx       = COORD_W'($signed(active_piece_grid.x)) + COORD_W'(lx);
            wy       = COORD_W'($signed(active_piece_grid.y)) + COORD_W'(ly);
            cell_bit = ROW_W'(LAST_ROW - wy);
            if (active_piece_grid.piece[ly][lx]) begin
               if (wy < ZERO) begin
                  merge_dead = 1'b1;
               end else if ((wy <= LAST_ROW) && (wx >= ZERO) && (wx <= LAST_COL)) begin
                  for (int c = 0; c < int'(W); c++) begin
                     if (wx == COORD_W'(c)) begin
                        if (screen_q.screen[c][cell_bit]) begin
                           merge_dead = 1'b1;
                        end else begin
                           merge_screen.screen[c][cell_bit] = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // Row scan: full-row detect and the board with that row removed and everything above shifted down
   logic [ROW_W-1:0]            scan_bit;
   logic                        row_full;
   game_state_pkg::game_state_t shifted_screen;

   always_comb begin
      scan_bit       = ROW_W'(H - 1) - row_q;
      row_full       = 1'b1;
      shifted_screen = screen_q;
      for (int c = 0; c < int'(W); c++) begin
         row_full = row_full & screen_q.screen[c][scan_bit];
         for (int k = 0; k < int'(H) - 1; k++) begin
            if (ROW_W'(k) >= scan_bit) begin
               shifted_screen.screen[c][k] = screen_q.screen[c][k+1];
            end
         end
         shifted_screen.screen[c][H-1] = 1'b0;
      end
   end

   // Next state and registered-output values
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      row_d      = row_q;
      count_d    = count_q;
      lines_d    = lines_q;
      screen_d   = screen_q;
      top_out_d  = top_out_q;
      spawn_d    = 1'b0;
`ifdef LOCK_RESET_ON_MOVE_EN
      resets_d   = resets_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (hard_drop) begin
               state_d = ST_MERGE;
            end else if (active_piece_toutching) begin
               state_d    = ST_DELAY;
               lock_cnt_d = '0;
            end
         end
         ST_DELAY: begin
            if (hard_drop) begin
               state_d = ST_MERGE;
            end else if (gravity_tick) begin
               lock_cnt_d = lock_cnt_q + CNT_W'(1);
               if ((lock_cnt_q + CNT_W'(1)) == CNT_W'(LOCK_TICKS)) begin
                  state_d = ST_MERGE;
               end
`ifdef LOCK_RESET_ON_MOVE_EN
            end else if (move_accept) begin
               lock_cnt_d = '0;
               resets_d   = resets_q + CNT_W'(1);
`endif
            end else if (!active_piece_toutching) begin
               state_d    = ST_IDLE;
               lock_cnt_d = '0;
            end
         end
         ST_MERGE: begin
            if (merge_dead) begin
               top_out_d = 1'b1;
               state_d   = ST_DEAD;
            end else begin
               screen_d = merge_screen;
               row_d    = ROW_W'(H - 1);
               count_d  = '0;
               state_d  = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // A cleared row is re-checked because the row above has dropped into it
            if (row_full) begin
               screen_d = shifted_screen;
               count_d  = count_q + LINES_W'(1);
            end else if (row_q == '0) begin
               state_d = ST_DONE;
               spawn_d = 1'b1;
               lines_d = count_q;
            end else begin
               row_d = row_q - ROW_W'(1);
            end
         end
         ST_DONE: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
`ifdef LOCK_RESET_ON_MOVE_EN
            resets_d   = '0;
`endif
         end
         ST_DEAD: begin
            state_d = ST_DEAD;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_MERGE) || (state_d == ST_SCAN) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
         row_q      <= '0;
         count_q    <= '0;
         lines_q    <= '0;
         screen_q   <= '0;
         spawn_q    <= 1'b0;
         busy_q     <= 1'b0;
         top_out_q  <= 1'b0;
`ifdef LOCK_RESET_ON_MOVE_EN
         resets_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         row_q      <= row_d;
         count_q    <= count_d;
         lines_q    <= lines_d;
         screen_q   <= screen_d;
         spawn_q    <= spawn_d;
         busy_q     <= busy_d;
         top_out_q  <= top_out_d;
`ifdef LOCK_RESET_ON_MOVE_EN
         resets_q   <= resets_d;
`endif
      end
   end

   assign GAME_fixed_state = screen_q;
   assign lock_busy        = busy_q;
   assign spawn_req        = spawn_q;
   assign lines_cleared    = lines_q;
   assign top_out          = top_out_q;

endmodule

// File: tb/tb_piece_lock_controller.sv
// Self-checking bench for piece_lock_controller: a board model predicts each lock into a scoreboard.
// Also covers the LOCK_RESET_ON_MOVE_EN build when that macro is defined.

module tb_piece_lock_controller;

   logic                           clk = 1'b0;
   logic                           reset;
   tetris_pkg::active_piece_grid_t grid;
   logic                           touching;
   logic                           tick;
   logic                           hard_drop;
   logic                           piece_moved;
   game_state_pkg::game_state_t    board;
   logic                           lock_busy;
   logic                           spawn_req;
   logic [2:0]                     lines_cleared;
   logic                           top_out;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      game_state_pkg::game_state_t scr;
      int                          lines;
      bit                          dead;
   } exp_t;

   exp_t exp_q[$];
   bit   mb[20][10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piece_lock_controller #(
      .LOCK_TICKS      (2),
      .MAX_LOCK_RESETS (2)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .active_piece_grid      (grid),
      .active_piece_toutching (touching),
      .gravity_tick           (tick),
      .hard_drop              (hard_drop),
      .piece_moved            (piece_moved),
      .GAME_fixed_state       (board),
      .lock_busy              (lock_busy),
      .spawn_req              (spawn_req),
      .lines_cleared          (lines_cleared),
      .top_out                (top_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic tetris_pkg::active_piece_grid_t mk(input int x, input int y, input logic [15:0] bits);
      tetris_pkg::active_piece_grid_t g;
      g.x     = 6'(x);
      g.y     = 6'(y);
      g.piece = bits;
      return g;
   endfunction

   function automatic game_state_pkg::game_state_t model_screen();
      game_state_pkg::game_state_t s;
      s = '0;
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 10; x++)
            s.screen[x][19-y] = mb[y][x];
      return s;
   endfunction

   // Predict the outcome of locking the current grid and push it to the scoreboard
   task automatic model_lock();
      exp_t e;
      bit   dead;
      bit   full;
      bit   nb[20][10];
      int   wx, wy, dst, lines;
      dead  = 0;
      lines = 0;
      for (int ly = 0; ly < 4; ly++)
         for (int lx = 0; lx < 4; lx++)
            if (grid.piece[ly][lx]) begin
               wx = int'(grid.x) + lx;
               wy = int'(grid.y) + ly;
               if (wy < 0) dead = 1;
               else if (wy <= 19 && wx >= 0 && wx <= 9 && mb[wy][wx]) dead = 1;
            end
      if (!dead) begin
         for (int ly = 0; ly < 4; ly++)
            for (int lx = 0; lx < 4; lx++)
               if (grid.piece[ly][lx]) begin
                  wx = int'(grid.x) + lx;
                  wy = int'(grid.y) + ly;
                  if (wy <= 19 && wx >= 0 && wx <= 9) mb[wy][wx] = 1;
               end
         for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++)
               nb[y][x] = 0;
         dst = 19;
         for (int y = 19; y >= 0; y--) begin
            full = 1;
            for (int x = 0; x < 10; x++) full = full & mb[y][x];
            if (full) lines++;
            else begin
               for (int x = 0; x < 10; x++) nb[dst][x] = mb[y][x];
               dst--;
            end
         end
         mb = nb;
      end
      e.scr   = model_screen();
      e.lines = lines;
      e.dead  = dead;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      reset       = 1'b1;
      hard_drop   = 1'b0;
      tick        = 1'b0;
      touching    = 1'b0;
      piece_moved = 1'b0;
      step();
      step();
      reset = 1'b0;
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 10; x++)
            mb[y][x] = 0;
      exp_q.delete();
   endtask

   // Wait for the lock started at cycle c0 to finish and compare it against the scoreboard
   task automatic await_result(input string name, input int c0, input bit extra_drop);
      exp_t e;
      bit   seen;
      int   spawns;
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         if (extra_drop && i == 4) hard_drop = 1'b1;
         step();
         hard_drop = 1'b0;
         seen = spawn_req || top_out;
      end
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard: no expected entry queued", name);
         return;
      end
      e = exp_q.pop_front();
      if (!seen) begin
         n_fail++;
         $display("FAIL %s timeout: no spawn_req/top_out within 80 cycles", name);
         return;
      end
      if (e.dead) begin
         n_tests++;
         if (top_out !== 1'b1 || spawn_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s top_out: top_out=%b spawn_req=%b expected 1/0", name, top_out, spawn_req);
         end
         n_tests++;
         if (board !== e.scr) begin
            n_fail++;
            $display("FAIL %s dead_screen: got %h expected %h", name, board, e.scr);
         end
         spawns = 0;
         for (int i = 0; i < 30; i++) begin
            step();
            if (spawn_req) spawns++;
         end
         n_tests++;
         if (spawns != 0 || top_out !== 1'b1) begin
            n_fail++;
            $display("FAIL %s dead_quiet: spawns=%0d top_out=%b expected 0/1", name, spawns, top_out);
         end
      end else begin
         n_tests++;
         if (cyc - c0 != 22 + e.lines) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc - c0, 22 + e.lines);
         end
         n_tests++;
         if (int'(lines_cleared) != e.lines) begin
            n_fail++;
            $display("FAIL %s lines_cleared: got %0d expected %0d", name, lines_cleared, e.lines);
         end
         n_tests++;
         if (board !== e.scr) begin
            n_fail++;
            $display("FAIL %s screen: got %h expected %h", name, board, e.scr);
         end
         step();
         n_tests++;
         if (spawn_req !== 1'b0 || int'(lines_cleared) != e.lines || lock_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: spawn_req=%b lines=%0d busy=%b expected 0/%0d/0",
                     name, spawn_req, lines_cleared, lock_busy, e.lines);
         end
      end
   endtask

   task automatic drop_piece(input string name, input tetris_pkg::active_piece_grid_t g, input bit extra_drop);
      int c0;
      grid = g;
      model_lock();
      hard_drop = 1'b1;
      c0 = cyc;
      step();
      hard_drop = 1'b0;
      n_tests++;
      if (lock_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s merge_start: lock_busy=%b expected 1", name, lock_busy);
      end
      await_result(name, c0, extra_drop);
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if (board !== '0 || lock_busy !== 1'b0 || spawn_req !== 1'b0 ||
          lines_cleared !== 3'd0 || top_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: board=%h busy=%b spawn=%b lines=%0d top=%b expected all 0",
                  board, lock_busy, spawn_req, lines_cleared, top_out);
      end
   endtask

   task automatic test_o_piece();
      apply_reset();
      drop_piece("o_piece", mk(4, 18, 16'h0066), 1'b0);
      n_tests++;
      if (board.screen[5] !== 20'h00003 || board.screen[6] !== 20'h00003) begin
         n_fail++;
         $display("FAIL o_piece_cols: col5=%h col6=%h expected 00003", board.screen[5], board.screen[6]);
      end
   endtask

   task automatic test_edge_drop();
      apply_reset();
      drop_piece("edge_right", mk(8, 19, 16'h000F), 1'b0);
      drop_piece("edge_left", mk(-2, 19, 16'h000F), 1'b0);
      drop_piece("edge_floor", mk(5, 19, 16'h0011), 1'b0);
   endtask

   task automatic test_single_clear();
      apply_reset();
      drop_piece("row_a", mk(0, 19, 16'h000F), 1'b0);
      drop_piece("row_b", mk(4, 19, 16'h000F), 1'b0);
      drop_piece("row_c", mk(8, 19, 16'h0001), 1'b0);
      drop_piece("single_clear", mk(9, 16, 16'h1111), 1'b0);
      n_tests++;
      if (board.screen[9] !== 20'h00007 || lines_cleared !== 3'd1) begin
         n_fail++;
         $display("FAIL single_clear_col9: col9=%h lines=%0d expected 00007/1", board.screen[9], lines_cleared);
      end
   endtask

   task automatic test_four_lines();
      apply_reset();
      drop_piece("block_a", mk(0, 16, 16'hFFFF), 1'b0);
      drop_piece("block_b", mk(4, 16, 16'hFFFF), 1'b0);
      drop_piece("col_8", mk(8, 16, 16'h1111), 1'b0);
      drop_piece("four_lines", mk(9, 16, 16'h1111), 1'b0);
      n_tests++;
      if (board !== '0 || lines_cleared !== 3'd4) begin
         n_fail++;
         $display("FAIL four_lines_final: board=%h lines=%0d expected 0/4", board, lines_cleared);
      end
   endtask

   task automatic test_lock_delay();
      int c0;
      apply_reset();
      grid     = mk(4, 18, 16'h0066);
      touching = 1'b1;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      touching = 1'b0;
      step();
      step();
      step();
      n_tests++;
      if (lock_busy !== 1'b0 || spawn_req !== 1'b0) begin
         n_fail++;
         $display("FAIL lift_off: busy=%b spawn=%b expected 0/0", lock_busy, spawn_req);
      end
      touching = 1'b1;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      n_tests++;
      if (lock_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL first_tick: lock_busy=%b expected 0 (counter must restart)", lock_busy);
      end
`ifndef LOCK_RESET_ON_MOVE_EN
      piece_moved = 1'b1;
`endif
      step();
      piece_moved = 1'b0;
      step();
      model_lock();
      tick = 1'b1;
      c0 = cyc;
      step();
      tick = 1'b0;
      touching = 1'b0;
      n_tests++;
      if (lock_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL second_tick: lock_busy=%b expected 1", lock_busy);
      end
      await_result("lock_delay", c0, 1'b0);
   endtask

`ifdef LOCK_RESET_ON_MOVE_EN
   task automatic test_move_reset();
      int c0;
      apply_reset();
      grid     = mk(0, 18, 16'h0066);
      touching = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         n_tests++;
         if (lock_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL move_reset_tick%0d: lock_busy=%b expected 0", i, lock_busy);
         end
         piece_moved = 1'b1;
         step();
         piece_moved = 1'b0;
      end
      model_lock();
      tick = 1'b1;
      c0 = cyc;
      step();
      tick = 1'b0;
      touching = 1'b0;
      n_tests++;
      if (lock_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL move_reset_lock: lock_busy=%b expected 1 (third move must be ignored)", lock_busy);
      end
      await_result("move_reset", c0, 1'b0);
   endtask
`endif

   task automatic test_top_out();
      apply_reset();
      drop_piece("above_top", mk(4, -1, 16'h0066), 1'b0);
      grid = mk(0, 18, 16'h0066);
      hard_drop = 1'b1;
      step();
      hard_drop = 1'b0;
      for (int i = 0; i < 25; i++) step();
      n_tests++;
      if (board !== '0 || top_out !== 1'b1 || spawn_req !== 1'b0 || lock_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL dead_ignores: board=%h top=%b spawn=%b busy=%b expected 0/1/0/0",
                  board, top_out, spawn_req, lock_busy);
      end
      apply_reset();
      n_tests++;
      if (top_out !== 1'b0) begin
         n_fail++;
         $display("FAIL top_out_reset: top_out=%b expected 0", top_out);
      end
      drop_piece("first_o", mk(4, 18, 16'h0066), 1'b0);
      drop_piece("overlap", mk(4, 18, 16'h0066), 1'b0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drop_piece("busy_drop", mk(0, 18, 16'h0066), 1'b1);
      drop_piece("next_drop", mk(6, 18, 16'h0033), 1'b0);
   endtask

   task automatic test_reset_abort();
      int spawns;
      apply_reset();
      grid = mk(0, 18, 16'h0066);
      hard_drop = 1'b1;
      step();
      hard_drop = 1'b0;
      for (int i = 0; i < 4; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_tests++;
      if (lock_busy !== 1'b0 || board !== '0) begin
         n_fail++;
         $display("FAIL reset_abort: busy=%b board=%h expected 0/0", lock_busy, board);
      end
      spawns = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (spawn_req) spawns++;
      end
      n_tests++;
      if (spawns != 0) begin
         n_fail++;
         $display("FAIL reset_abort_spawn: spawns=%0d expected 0", spawns);
      end
   endtask

   initial begin
      reset       = 1'b1;
      grid        = '0;
      touching    = 1'b0;
      tick        = 1'b0;
      hard_drop   = 1'b0;
      piece_moved = 1'b0;
      test_reset();
      test_o_piece();
      test_edge_drop();
      test_single_clear();
      test_four_lines();
      test_lock_delay();
`ifdef LOCK_RESET_ON_MOVE_EN
      test_move_reset();
`endif
      test_top_out();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
